bsg_config_rom_streamer: RTL and testbench
==========================================

Name: bsg_config_rom_streamer

Overview:
- Parametrised successor to the combinational configuration ROM.
- Holds els_p configuration words of width_p bits, supplied as a flattened parameter.
- Serves requests over a valid/ready request port and a valid/yumi response port.
- Each word is serialised into out_width_p-bit beats, so the host link can be narrower than the ROM.
- Supports single-word reads and bursts (start address through the last entry), and flags out-of-range addresses.

Parameters:
- width_p, 32, width of one configuration word.
- out_width_p, 8, response beat width; width_p % out_width_p == 0 is required.
- els_p, 20, number of ROM entries; must be >= 1.
- addr_width_p, 5, request address width; must be >= $clog2(els_p).
- init_p, all zeros, flattened ROM contents [els_p*width_p-1:0]; entry i occupies bits [i*width_p +: width_p].

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- v_i  in  1  request valid.
- addr_i  in  addr_width_p  request start address.
- burst_i  in  1  1 = burst from addr_i to els_p-1; 0 = single word.
- ready_o  out  1  request accepted when v_i & ready_o.
- v_o  out  1  response beat valid.
- data_o  out  out_width_p  response beat.
- last_o  out  1  final beat of the transaction.
- err_o  out  1  addr_i was out of range (addr_i >= els_p).
- yumi_i  in  1  consumer takes the beat; legal only when v_o = 1.

Behaviour:
- Derived constant: chunks_lp = width_p/out_width_p.
- Reset (asynchronous assert, release synchronous to clk_i):
  - state = IDLE; v_o = 0; data_o = 0; last_o = 0; err_o = 0; ready_o = 1.
  - Word and chunk counters clear to 0.
- States: IDLE, STREAM, ERR.
- IDLE:
  - ready_o = 1, v_o = 0.
  - On v_i & ready_o: latch addr_i and burst_i.
  - addr_i < els_p → STREAM, word pointer = addr_i, chunk = 0.
  - addr_i >= els_p → ERR.
- STREAM:
  - ready_o = 0, v_o = 1.
  - data_o = chunk `chunk` of word[ptr], LSB chunk first, i.e. word[ptr][chunk*out_width_p +: out_width_p].
  - On yumi_i: chunk increments; at chunk == chunks_lp-1 it wraps to 0 and ptr increments.
  - last_o = 1 only when chunk == chunks_lp-1 and (burst == 0 or ptr == els_p-1).
  - yumi_i while last_o = 1 → IDLE.
- ERR:
  - ready_o = 0, v_o = 1, data_o = 0, err_o = 1, last_o = 1.
  - yumi_i → IDLE; err_o clears on that transition.
- Latency:
  - The first beat is presented the cycle after acceptance; data_o and v_o are registered, with no combinational path from v_i.
  - Subsequent beats follow the cycle after each yumi_i; sustained throughput is one beat per cycle.
- Back-pressure: while v_o = 1 and yumi_i = 0, data_o, last_o and err_o hold stable.
- Request handling:
  - No new request is accepted until the cycle after the last beat's yumi_i; ready_o is asserted in IDLE only.
  - v_i while ready_o = 0 is ignored; it is not queued.
- Burst from ptr == els_p-1 behaves as a single read.
- Width rules:
  - The word pointer is addr_width_p bits and the chunk counter is max(1, $clog2(chunks_lp)) bits.
  - Comparisons against els_p are made at addr_width_p+1 bits to avoid wrap.
- chunks_lp == 1: every beat is a full word; last_o depends only on the ptr/burst condition.
- Reset mid-transaction: aborts immediately to IDLE with v_o = 0; no partial beat is replayed after release.
- Assertions (simulation only):
  - yumi_i with v_o = 0 is an error.
  - width_p % out_width_p != 0 is an elaboration error.

Test Plan:
- Single read: init entry0 = 0x00030602, width 32/out 8, addr 0, burst 0 → beats 0x02, 0x06, 0x03, 0x00; last_o on the 4th beat only; err_o = 0; ready_o = 1 the cycle after the final yumi_i.
- Burst tail: entries 18 = 0x00000100 and 19 = 0x000000C8, els 20, addr 18, burst 1 → 8 beats 0x00, 0x01, 0x00, 0x00, 0xC8, 0x00, 0x00, 0x00; last_o on beat 8.
- Out of range: addr 25, els 20 → exactly one beat with data_o = 0, err_o = 1, last_o = 1; IDLE after yumi_i.
- Back-pressure: hold yumi_i low for 5 cycles mid-burst → data_o, last_o and v_o are unchanged; random yumi_i over a full burst from 0 yields 80 beats matching init_p in order.
- Reset mid-burst: assert reset_i asynchronously (not on a clock edge) at beat 3 → v_o = 0 immediately; after release ready_o = 1, and a new single read of addr 9 returns 0x3E, 0x9D, 0xEC, 0x07.
- Parameter sweep: out_width_p = 32 (chunks 1) and out_width_p = 16 → beat counts of 1 and 2 per word, last_o correct, and a burst from els_p-1 yields a single word.

Source files
------------

// File: rtl/bsg_config_rom_streamer.sv
// Configuration ROM served as a stream of narrow beats, single-word or burst to the last entry.
// Latency: first beat the cycle after request acceptance, then one beat per cycle while yumi_i is held.
// Backpressure: beat outputs hold while v_o & ~yumi_i; requests are accepted only in IDLE and never queued.
module bsg_config_rom_streamer #(
  parameter int width_p      = 32,
  parameter int out_width_p  = 8,
  parameter int els_p        = 20,
  parameter int addr_width_p = 5,
  parameter logic [els_p*width_p-1:0] init_p = '0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic                    burst_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [out_width_p-1:0]  data_o,
  output logic                    last_o,
  output logic                    err_o,
  input  logic                    yumi_i
);

  localparam int chunks_lp  = width_p / out_width_p;
  localparam int chunk_w_lp = (chunks_lp > 1) ? $clog2(chunks_lp) : 1;

  localparam logic [chunk_w_lp-1:0]   last_chunk_lp = chunk_w_lp'(chunks_lp - 1);
  // Range checks use one extra bit so els_p == 2**addr_width_p cannot wrap.
  localparam logic [addr_width_p:0]   els_lp        = (addr_width_p + 1)'(els_p);
  localparam logic [addr_width_p:0]   last_ptr_lp   = (addr_width_p + 1)'(els_p - 1);

  if (width_p % out_width_p != 0) begin : g_bad_width
    $error("bsg_config_rom_streamer: width_p must be a multiple of out_width_p");
  end
  if (els_p < 1) begin : g_bad_els
    $error("bsg_config_rom_streamer: els_p must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_ERR    = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_n;
  logic [addr_width_p-1:0] r_ptr;
  logic [chunk_w_lp-1:0]   r_chunk;
  logic                    r_burst;

  logic [width_p-1:0]      w_rom    [els_p];
  logic [out_width_p-1:0]  w_chunks [chunks_lp];
  logic [width_p-1:0]      w_word;
  logic                    w_addr_ok;
  logic                    w_last_chunk;
  logic                    w_last_word;
  logic                    w_last_beat;

  // Unpack the flattened contents into one word per entry.
  for (genvar i = 0; i < els_p; i++) begin : g_rom
    assign w_rom[i] = init_p[i*width_p +: width_p];
  end

  assign w_word = w_rom[r_ptr];

  // Split the current word into beats, LSB chunk at index 0.
  for (genvar c = 0; c < chunks_lp; c++) begin : g_chunk
    assign w_chunks[c] = w_word[c*out_width_p +: out_width_p];
  end

  assign w_addr_ok    = ({1'b0, addr_i} < els_lp);
  assign w_last_chunk = (r_chunk == last_chunk_lp);
  // A burst starting at the final entry naturally degenerates to a single read.
  assign w_last_word  = !r_burst || ({1'b0, r_ptr} == last_ptr_lp);
  assign w_last_beat  = w_last_chunk && w_last_word;

  // State register; reset aborts any transaction so no partial beat survives.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next state and outputs, decoded from registered state only (no path from v_i).
  always_comb begin
    w_state_n = r_state;
    ready_o   = 1'b0;
    v_o       = 1'b0;
    data_o    = '0;
    last_o    = 1'b0;
    err_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (v_i) begin
          w_state_n = w_addr_ok ? S_STREAM : S_ERR;
        end
      end
      S_STREAM: begin
        v_o    = 1'b1;
        data_o = w_chunks[r_chunk];
        last_o = w_last_beat;
        if (yumi_i && w_last_beat) begin
          w_state_n = S_IDLE;
        end
      end
      S_ERR: begin
        v_o    = 1'b1;
        err_o  = 1'b1;
        last_o = 1'b1;
        if (yumi_i) begin
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // Request capture in IDLE and word/chunk stepping on each consumed beat.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ptr   <= '0;
      r_chunk <= '0;
      r_burst <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (v_i) begin
        r_ptr   <= addr_i;
        r_chunk <= '0;
        r_burst <= burst_i;
      end
    end else if (r_state == S_STREAM && yumi_i) begin
      if (w_last_chunk) begin
        r_chunk <= '0;
        r_ptr   <= r_ptr + 1'b1;
      end else begin
        r_chunk <= r_chunk + 1'b1;
      end
    end
  end

  // A consumer may only take a beat that is being offered.
  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o));

endmodule

// File: tb/tb_bsg_config_rom_streamer.sv
module tb_bsg_config_rom_streamer;

  localparam int W  = 32;
  localparam int EL = 20;
  localparam int AW = 5;

  function automatic logic [EL*W-1:0] mk_init();
    logic [EL*W-1:0] v;
    logic [31:0]     w;
    v = '0;
    for (int i = 0; i < EL; i++) begin
      w = (32'h9E3779B9 * (i + 1)) ^ (32'h00A5_5A00 + 32'(i));
      if (i == 0)  w = 32'h00030602;
      if (i == 9)  w = 32'h07EC9D3E;
      if (i == 18) w = 32'h00000100;
      if (i == 19) w = 32'h000000C8;
      v[i*W +: W] = w;
    end
    return v;
  endfunction

  localparam logic [EL*W-1:0] INIT = mk_init();

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr = '0;
  logic          burst = 1'b0;
  logic          v = 1'b0;
  logic          yumi = 1'b0;
  int            sel = 0;

  logic       v_a, v_b, v_c, y_a, y_b, y_c;
  logic       rdy_a, rdy_b, rdy_c, vo_a, vo_b, vo_c;
  logic       last_a, last_b, last_c, err_a, err_b, err_c;
  logic [7:0]  d_a;
  logic [15:0] d_b;
  logic [31:0] d_c;

  logic        m_rdy, m_v, m_last, m_err;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  assign v_a = v & (sel == 0);
  assign v_b = v & (sel == 1);
  assign v_c = v & (sel == 2);
  assign y_a = yumi & (sel == 0);
  assign y_b = yumi & (sel == 1);
  assign y_c = yumi & (sel == 2);

  bsg_config_rom_streamer #(.width_p(W), .out_width_p(8), .els_p(EL), .addr_width_p(AW), .init_p(INIT)) dut_a (
    .clk_i(clk), .reset_i(rst), .v_i(v_a), .addr_i(addr), .burst_i(burst), .ready_o(rdy_a),
    .v_o(vo_a), .data_o(d_a), .last_o(last_a), .err_o(err_a), .yumi_i(y_a));
  bsg_config_rom_streamer #(.width_p(W), .out_width_p(16), .els_p(EL), .addr_width_p(AW), .init_p(INIT)) dut_b (
    .clk_i(clk), .reset_i(rst), .v_i(v_b), .addr_i(addr), .burst_i(burst), .ready_o(rdy_b),
    .v_o(vo_b), .data_o(d_b), .last_o(last_b), .err_o(err_b), .yumi_i(y_b));
  bsg_config_rom_streamer #(.width_p(W), .out_width_p(32), .els_p(EL), .addr_width_p(AW), .init_p(INIT)) dut_c (
    .clk_i(clk), .reset_i(rst), .v_i(v_c), .addr_i(addr), .burst_i(burst), .ready_o(rdy_c),
    .v_o(vo_c), .data_o(d_c), .last_o(last_c), .err_o(err_c), .yumi_i(y_c));

  always_comb begin
    m_rdy = rdy_a; m_v = vo_a; m_last = last_a; m_err = err_a; m_data = {24'h0, d_a};
    if (sel == 1) begin
      m_rdy = rdy_b; m_v = vo_b; m_last = last_b; m_err = err_b; m_data = {16'h0, d_b};
    end else if (sel == 2) begin
      m_rdy = rdy_c; m_v = vo_c; m_last = last_c; m_err = err_c; m_data = d_c;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] q[$];   // {err, last, data}
  logic [EL*W-1:0] init_v;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected beats for a request to a DUT with beat width cw.
  task automatic push_model(input int a, input bit b, input int cw);
    int n, lw;
    logic [31:0] word, mask;
    n = W / cw;
    mask = (cw == 32) ? 32'hFFFF_FFFF : ((32'h1 << cw) - 32'h1);
    if (a >= EL) begin
      q.push_back({1'b1, 1'b1, 32'h0});
    end else begin
      lw = b ? EL - 1 : a;
      for (int w = a; w <= lw; w++) begin
        word = init_v[w*W +: W];
        for (int c = 0; c < n; c++)
          q.push_back({1'b0, (c == n - 1) && (w == lw), (word >> (c * cw)) & mask});
      end
    end
  endtask

  // Present a request at a negedge; the first beat must be up one cycle later.
  task automatic request(input int a, input bit b);
    @(negedge clk);
    chk("ready_idle", m_rdy, 1);
    v = 1'b1; addr = AW'(a); burst = b;
    @(negedge clk);
    v = 1'b0;
    chk("first_beat_v", m_v, 1);
  endtask

  // Consume beats against the scoreboard; optional stall and early stop.
  task automatic drain(input int pct, input int stall_at, input int max_beats, input bit chk_rdy);
    int cyc, beats;
    logic [34:0] snap;
    cyc = 0; beats = 0;
    while (q.size() > 0 && beats < max_beats && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      yumi = 1'b0;
      if (m_v && beats == stall_at) begin
        snap = {m_v, m_err, m_last, m_data};
        repeat (5) begin
          @(negedge clk);
          chk("hold", {m_v, m_err, m_last, m_data}, snap);
        end
        stall_at = -1;
      end
      if (m_v && $urandom_range(99) < pct) begin
        chk("beat", {m_err, m_last, m_data}, q.pop_front());
        yumi = 1'b1;
        beats++;
      end
    end
    @(negedge clk);
    yumi = 1'b0;
    if (cyc >= 2000) begin
      chk("timeout_left", q.size(), 0);
      q.delete();
    end
    if (chk_rdy) chk("ready_after_last", m_rdy, 1);
  endtask

  initial begin
    init_v = INIT;
    #23;
    chk("rst_ready", m_rdy, 1);
    chk("rst_v", m_v, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_err", m_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single read of entry 0.
    sel = 0;
    request(0, 0);
    q.push_back({2'b00, 32'h02}); q.push_back({2'b00, 32'h06});
    q.push_back({2'b00, 32'h03}); q.push_back({2'b01, 32'h00});
    drain(100, -1, 1000, 1);

    // Burst tail 18..19.
    request(18, 1);
    q.push_back({2'b00, 32'h00}); q.push_back({2'b00, 32'h01});
    q.push_back({2'b00, 32'h00}); q.push_back({2'b00, 32'h00});
    q.push_back({2'b00, 32'hC8}); q.push_back({2'b00, 32'h00});
    q.push_back({2'b00, 32'h00}); q.push_back({2'b01, 32'h00});
    drain(100, -1, 1000, 1);

    // Out-of-range address.
    request(25, 1);
    q.push_back({2'b11, 32'h0});
    drain(100, -1, 1000, 1);
    chk("err_cleared", m_err, 0);

    // Burst with a mid-stream stall, then a full random-yumi burst.
    request(15, 1);
    push_model(15, 1, 8);
    drain(100, 6, 1000, 1);
    request(0, 1);
    push_model(0, 1, 8);
    drain(60, -1, 1000, 1);

    // Asynchronous reset while beat 3 is on the bus.
    request(0, 1);
    push_model(0, 1, 8);
    drain(100, -1, 2, 0);
    chk("beat3_v", m_v, 1);
    #3 rst = 1'b1;
    #1 chk("rst_async_v", m_v, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_release_ready", m_rdy, 1);
    chk("rst_release_v", m_v, 0);
    request(9, 0);
    q.push_back({2'b00, 32'h3E}); q.push_back({2'b00, 32'h9D});
    q.push_back({2'b00, 32'hEC}); q.push_back({2'b01, 32'h07});
    drain(100, -1, 1000, 1);

    // 16-bit beats.
    sel = 1;
    request(0, 0);
    q.push_back({2'b00, 32'h0602}); q.push_back({2'b01, 32'h0003});
    drain(100, -1, 1000, 1);
    request(3, 1);
    push_model(3, 1, 16);
    drain(70, -1, 1000, 1);
    request(19, 1);
    q.push_back({2'b00, 32'h00C8}); q.push_back({2'b01, 32'h0000});
    drain(100, -1, 1000, 1);

    // Full-word beats.
    sel = 2;
    request(9, 0);
    q.push_back({2'b01, 32'h07EC9D3E});
    drain(100, -1, 1000, 1);
    request(12, 1);
    push_model(12, 1, 32);
    drain(70, -1, 1000, 1);
    request(19, 1);
    q.push_back({2'b01, 32'h000000C8});
    drain(100, -1, 1000, 1);
    request(31, 0);
    q.push_back({2'b11, 32'h0});
    drain(100, -1, 1000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
